// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the inst/data SRAM-like port arbiter: grant states,
// requester ids and the request payload carried onto the memory port.
package sram_req_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned WEN_W  = 4;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [WEN_W-1:0]  wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_id_order_fifo.sv
// One-bit source-id FIFO recording the order of accepted transactions.
// head_c bypasses the incoming id when empty so a same-cycle response can pop it.
module id_order_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] ids;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        do_pop     = pop && (!empty || push);
        do_push    = push && (!full || pop);
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign head_c = empty ? push_id : ids[rd_ptr];

    // Full/empty are registered so a pop while full frees the slot next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between inst and data requesters, routing
// zero-latency responses back in acceptance order; err_spurious is registered.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING    = 4,
    parameter int unsigned DATA_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_en,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [WEN_W-1:0]  inst_wen,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic [ADDR_W-1:0] inst_addr_ok_addr,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [WEN_W-1:0]  data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic [ADDR_W-1:0] data_addr_ok_addr,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              m_en,
    output logic              m_wr,
    output logic [SIZE_W-1:0] m_size,
    output logic [WEN_W-1:0]  m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err_spurious
);

    localparam int unsigned CNT_W   = $clog2(OUTSTANDING) + 1;
    localparam int unsigned BURST_W = $clog2(DATA_BURST_MAX + 1);

    state_e             state;
    state_e             state_next;
    logic [BURST_W-1:0] burst;
    logic               burst_hit;
    logic               gnt_vld;
    logic               gnt_src;
    logic               issue;
    logic               push;
    logic               pop;
    logic               rsp_vld;
    logic               spurious_c;
    logic               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    sram_req_t          inst_req;
    sram_req_t          data_req;
    sram_req_t          m_req;

    always_comb begin
        inst_req = '{wr: inst_wr, size: inst_size, wen: inst_wen, addr: inst_addr, wdata: inst_wdata};
        data_req = '{wr: data_wr, size: data_size, wen: data_wen, addr: data_addr, wdata: data_wdata};
    end

    // Grant selection and next state; a lock holds the port for one requester.
    always_comb begin
        state_next = state;
        gnt_vld    = 1'b0;
        gnt_src    = SRC_INST;
        burst_hit  = (burst == BURST_W'(DATA_BURST_MAX)) && inst_en;
        unique case (state)
            IDLE: begin
                if (data_en && !burst_hit) begin
                    gnt_vld = 1'b1;
                    gnt_src = SRC_DATA;
                end else if (inst_en) begin
                    gnt_vld = 1'b1;
                end
            end
            LOCK_I: gnt_vld = inst_en;
            LOCK_D: begin
                gnt_vld = data_en;
                gnt_src = SRC_DATA;
            end
            default: ;
        endcase
        gnt_vld = gnt_vld && resetn;
        issue   = gnt_vld && !fifo_full;
        if (state == IDLE) begin
            if (issue && !m_addr_ok) begin
                state_next = (gnt_src == SRC_DATA) ? LOCK_D : LOCK_I;
            end
        end else if (m_addr_ok || !gnt_vld) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        m_req = '0;
        if (issue) begin
            m_req = (gnt_src == SRC_DATA) ? data_req : inst_req;
        end
    end

    assign m_en    = issue;
    assign m_wr    = m_req.wr;
    assign m_size  = m_req.size;
    assign m_wen   = m_req.wen;
    assign m_addr  = m_req.addr;
    assign m_wdata = m_req.wdata;

    assign push              = issue && m_addr_ok;
    assign inst_addr_ok      = push && (gnt_src == SRC_INST);
    assign data_addr_ok      = push && (gnt_src == SRC_DATA);
    assign inst_addr_ok_addr = (issue && gnt_src == SRC_INST) ? m_addr : '0;
    assign data_addr_ok_addr = (issue && gnt_src == SRC_DATA) ? m_addr : '0;

    // A response is spurious only if nothing is queued or arriving this cycle.
    assign rsp_vld      = m_data_ok && resetn;
    assign spurious_c   = rsp_vld && fifo_empty && !push;
    assign pop          = rsp_vld && !spurious_c;
    assign inst_data_ok = pop && (fifo_head == SRC_INST);
    assign data_data_ok = pop && (fifo_head == SRC_DATA);
    assign inst_rdata   = resetn ? m_rdata : '0;
    assign data_rdata   = resetn ? m_rdata : '0;

    id_order_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_order_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push    (push),
        .push_id (gnt_src),
        .pop     (pop),
        .head_c  (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Data-burst counter: saturates, cleared by inst traffic or an idle inst side.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            burst        <= '0;
            err_spurious <= 1'b0;
        end else begin
            err_spurious <= spurious_c;
            if (push && gnt_src == SRC_INST) begin
                burst <= '0;
            end else if (push) begin
                if (!inst_en) begin
                    burst <= '0;
                end else if (burst != BURST_W'(DATA_BURST_MAX)) begin
                    burst <= burst + BURST_W'(1);
                end
            end
        end
    end

    full_matches_count: assert property (@(posedge clk) disable iff (!resetn)
        fifo_full == (fifo_count == CNT_W'(OUTSTANDING)));

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed, table-driven checks of the inst/data SRAM port arbiter.
module tb_sram_req_arbiter;

    localparam logic [31:0] IA = 32'h0000_2000;
    localparam logic [31:0] DA = 32'h0000_1000;
    localparam logic [31:0] IW = 32'h1111_1111;
    localparam logic [31:0] DW = 32'h2222_2222;

    typedef struct {
        logic        ie, de, aok, dok;
        logic [31:0] rdata;
        logic        men;
        logic [31:0] maddr;
        logic        iaok, daok, idok, ddok, err;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_en, inst_wr, data_en, data_wr;
    logic [1:0]  inst_size, data_size, m_size;
    logic [3:0]  inst_wen, data_wen, m_wen;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_addr_ok_addr, inst_rdata, data_addr_ok_addr, data_rdata;
    logic        m_en, m_wr, m_addr_ok, m_data_ok, err_spurious;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(4), .DATA_BURST_MAX(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_en(inst_en), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wen(inst_wen),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_addr_ok_addr(inst_addr_ok_addr), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_wr(data_wr), .data_size(data_size), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_addr_ok_addr(data_addr_ok_addr), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_en(m_en), .m_wr(m_wr), .m_size(m_size), .m_wen(m_wen), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err_spurious(err_spurious)
    );

    function automatic vec_t v(input logic ie, de, aok, dok, input logic [31:0] rdata,
                               input logic men, input logic [31:0] maddr,
                               input logic iaok, daok, idok, ddok, err);
        vec_t t;
        t.ie = ie; t.de = de; t.aok = aok; t.dok = dok; t.rdata = rdata;
        t.men = men; t.maddr = maddr; t.iaok = iaok; t.daok = daok;
        t.idok = idok; t.ddok = ddok; t.err = err;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ie, de, aok, dok, input logic [31:0] rdata);
        inst_en = ie; data_en = de; m_addr_ok = aok; m_data_ok = dok; m_rdata = rdata;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_en"}, 32'(m_en), 32'd0);
        check({tag, " m_addr"}, m_addr, 32'd0);
        check({tag, " m_wdata"}, m_wdata, 32'd0);
        check({tag, " m_wr/size/wen"}, 32'({m_wr, m_size, m_wen}), 32'd0);
        check({tag, " addr_ok"}, 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        check({tag, " addr_ok_addr"}, inst_addr_ok_addr | data_addr_ok_addr, 32'd0);
        check({tag, " data_ok"}, 32'({inst_data_ok, data_data_ok}), 32'd0);
        check({tag, " rdata"}, inst_rdata | data_rdata, 32'd0);
        check({tag, " err_spurious"}, 32'(err_spurious), 32'd0);
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic [31:0] exp_wdata;
        logic [31:0] exp_iaddr;
        logic [31:0] exp_daddr;
        string       r;
        r = $sformatf("row%0d", idx);
        exp_wdata = (t.men && t.maddr == DA) ? DW : (t.men && t.maddr == IA) ? IW : 32'd0;
        exp_iaddr = (t.men && t.maddr == IA) ? IA : 32'd0;
        exp_daddr = (t.men && t.maddr == DA) ? DA : 32'd0;
        @(negedge clk);
        drive(t.ie, t.de, t.aok, t.dok, t.rdata);
        #1;
        check({r, " m_en"}, 32'(m_en), 32'(t.men));
        check({r, " m_addr"}, m_addr, t.maddr);
        check({r, " m_wdata"}, m_wdata, exp_wdata);
        check({r, " inst_addr_ok"}, 32'(inst_addr_ok), 32'(t.iaok));
        check({r, " data_addr_ok"}, 32'(data_addr_ok), 32'(t.daok));
        check({r, " inst_addr_ok_addr"}, inst_addr_ok_addr, exp_iaddr);
        check({r, " data_addr_ok_addr"}, data_addr_ok_addr, exp_daddr);
        check({r, " inst_data_ok"}, 32'(inst_data_ok), 32'(t.idok));
        check({r, " data_data_ok"}, 32'(data_data_ok), 32'(t.ddok));
        check({r, " inst_rdata"}, inst_rdata, t.rdata);
        check({r, " data_rdata"}, data_rdata, t.rdata);
        check({r, " err_spurious"}, 32'(err_spurious), 32'(t.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_wr = 1'b0; inst_size = 2'd2; inst_wen = 4'h0; inst_addr = IA; inst_wdata = IW;
        data_wr = 1'b1; data_size = 2'd2; data_wen = 4'hF; data_addr = DA; data_wdata = DW;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        resetn = 1'b0;

        // Burst arbitration with a zero-latency response every cycle: D,D,D,D,I,...
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) vecs.push_back(v(1,1,1,1,32'h100 + 32'(k), 1,IA,1,0,1,0,0));
            else            vecs.push_back(v(1,1,1,1,32'h100 + 32'(k), 1,DA,0,1,0,1,0));
        end
        // Data locked while m_addr_ok is low; inst follows after the handshake.
        vecs.push_back(v(0,1,0,0,0,       1,DA,0,0,0,0,0));
        vecs.push_back(v(0,1,0,0,0,       1,DA,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,       1,DA,0,0,0,0,0));
        vecs.push_back(v(1,1,1,0,0,       1,DA,0,1,0,0,0));
        vecs.push_back(v(1,0,1,0,0,       1,IA,1,0,0,0,0));
        vecs.push_back(v(0,0,0,1,32'h15,  0,0,0,0,0,1,0));
        vecs.push_back(v(0,0,0,1,32'h16,  0,0,0,0,1,0,0));
        // Response ordering I,D,I,D.
        vecs.push_back(v(1,0,1,0,0,       1,IA,1,0,0,0,0));
        vecs.push_back(v(0,1,1,0,0,       1,DA,0,1,0,0,0));
        vecs.push_back(v(1,0,1,0,0,       1,IA,1,0,0,0,0));
        vecs.push_back(v(0,1,1,0,0,       1,DA,0,1,0,0,0));
        vecs.push_back(v(0,0,0,1,32'hA,   0,0,0,0,1,0,0));
        vecs.push_back(v(0,0,0,1,32'hB,   0,0,0,0,0,1,0));
        vecs.push_back(v(0,0,0,1,32'hC,   0,0,0,0,1,0,0));
        vecs.push_back(v(0,0,0,1,32'hD,   0,0,0,0,0,1,0));
        // Fill to OUTSTANDING, stall, pop frees the slot one cycle later.
        vecs.push_back(v(0,1,1,0,0,       1,DA,0,1,0,0,0));
        vecs.push_back(v(1,0,1,0,0,       1,IA,1,0,0,0,0));
        vecs.push_back(v(0,1,1,0,0,       1,DA,0,1,0,0,0));
        vecs.push_back(v(1,0,1,0,0,       1,IA,1,0,0,0,0));
        vecs.push_back(v(1,1,1,0,0,       0,0,0,0,0,0,0));
        vecs.push_back(v(1,1,1,1,32'h30,  0,0,0,0,0,1,0));
        vecs.push_back(v(1,1,1,0,0,       1,DA,0,1,0,0,0));
        vecs.push_back(v(0,0,0,1,32'h32,  0,0,0,0,1,0,0));
        vecs.push_back(v(1,0,1,1,32'h33,  1,IA,1,0,0,1,0));
        vecs.push_back(v(0,0,0,1,32'h34,  0,0,0,0,1,0,0));
        vecs.push_back(v(0,0,0,1,32'h35,  0,0,0,0,0,1,0));
        vecs.push_back(v(0,0,0,1,32'h36,  0,0,0,0,1,0,0));
        // Spurious response, then inst lock that drops its request.
        vecs.push_back(v(0,0,0,1,32'h37,  0,0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,       0,0,0,0,0,0,1));
        vecs.push_back(v(1,0,0,0,0,       1,IA,0,0,0,0,0));
        vecs.push_back(v(1,1,0,0,0,       1,IA,0,0,0,0,0));
        vecs.push_back(v(0,1,0,0,0,       0,0,0,0,0,0,0));
        vecs.push_back(v(0,1,1,0,0,       1,DA,0,1,0,0,0));
        vecs.push_back(v(0,0,0,1,32'h43,  0,0,0,0,0,1,0));

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset with two transactions outstanding discards them.
        apply(v(1,0,1,0,0, 1,IA,1,0,0,0,0), 100);
        apply(v(0,1,1,0,0, 1,DA,0,1,0,0,0), 101);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        #1;
        check_all_zero("midreset2");
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        apply(v(0,0,0,1,32'h55, 0,0,0,0,0,0,0), 102);
        apply(v(0,0,0,0,0,      0,0,0,0,0,0,1), 103);
        apply(v(0,0,0,0,0,      0,0,0,0,0,0,0), 104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
